// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package ram_arbiter_pkg;

  localparam int MAX_COUNT = 8;
  localparam int IDX_W     = $clog2(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last winner and wraps.
module ram_arbiter_rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int COUNT = 5
) (
  input  logic [COUNT-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [COUNT-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= COUNT; i++) begin
      idx = IDX_W'((int'(last) + i) % COUNT);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-requester front end for a single-command RAM controller, one transaction in flight.
// Define RAM_ARBITER_PRIORITY_EN to let requester COUNT-1 take priority, alternating with the round-robin set.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int COUNT  = 5,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic [COUNT-1:0]        REQ,
  input  logic [COUNT-1:0]        WE,
  input  logic [COUNT*ADDR_W-1:0] ADDR,
  input  logic [COUNT*DATA_W-1:0] WDATA,
  output logic [COUNT-1:0]        ACK,
  output logic [DATA_W-1:0]       RDATA,
  output logic                    RAM_REQ,
  output logic                    RAM_WE,
  output logic [ADDR_W-1:0]       RAM_ADDR,
  output logic [DATA_W-1:0]       RAM_WDATA,
  input  logic                    RAM_ACK,
  input  logic                    RAM_RVALID,
  input  logic [DATA_W-1:0]       RAM_RDATA
);

  localparam logic [COUNT-1:0] ONE = {{(COUNT-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick_idx;
  logic [COUNT-1:0] rr_req;
  logic [COUNT-1:0] rr_grant;
  logic [COUNT-1:0] grant;
  logic             rr_valid;
  logic             grant_valid;

  ram_arbiter_rr_pick #(.COUNT(COUNT)) u_pick (
    .req   (rr_req),
    .last  (last),
    .grant (rr_grant),
    .valid (rr_valid)
  );

`ifdef RAM_ARBITER_PRIORITY_EN
  localparam logic [COUNT-1:0] TOP_BIT = {1'b1, {(COUNT-1){1'b0}}};
  logic prio_last;

  assign rr_req = REQ & ~TOP_BIT;

  // The priority requester yields once after each win so the others are not starved.
  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_valid;
    if (REQ[COUNT-1] && (!prio_last || !rr_valid)) begin
      grant       = TOP_BIT;
      grant_valid = 1'b1;
    end
  end
`else
  assign rr_req      = REQ;
  assign grant       = rr_grant;
  assign grant_valid = rr_valid;
`endif

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (grant[i]) pick_idx = IDX_W'(i);
    end
  end

  // No pick while an ACK is out, so a requester still holding REQ is not reselected that cycle.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      RAM_REQ   <= 1'b0;
      RAM_WE    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
      ACK       <= '0;
      RDATA     <= '0;
      winner    <= '0;
      last      <= IDX_W'(COUNT - 1);
`ifdef RAM_ARBITER_PRIORITY_EN
      prio_last <= 1'b0;
`endif
    end else begin
      ACK <= '0;
      case (state)
        IDLE: begin
          if (grant_valid && (ACK == '0)) begin
            RAM_REQ   <= 1'b1;
            RAM_WE    <= WE[pick_idx];
            RAM_ADDR  <= ADDR[int'(pick_idx)*ADDR_W +: ADDR_W];
            RAM_WDATA <= WDATA[int'(pick_idx)*DATA_W +: DATA_W];
            winner    <= pick_idx;
            state     <= ISSUE;
`ifdef RAM_ARBITER_PRIORITY_EN
            prio_last <= grant[COUNT-1];
            if (!grant[COUNT-1]) last <= pick_idx;
`else
            last      <= pick_idx;
`endif
          end
        end
        ISSUE: begin
          if (RAM_ACK) begin
            RAM_REQ <= 1'b0;
            if (RAM_WE) begin
              ACK   <= ONE << winner;
              state <= IDLE;
            end else if (RAM_RVALID) begin
              RDATA <= RAM_RDATA;
              ACK   <= ONE << winner;
              state <= IDLE;
            end else begin
              state <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (RAM_RVALID) begin
            RDATA <= RAM_RDATA;
            ACK   <= ONE << winner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter in its default (round-robin) build.
module tb_ram_arbiter;

  localparam int COUNT  = 5;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;

  logic                    CLK;
  logic                    RESET_n;
  logic [COUNT-1:0]        REQ;
  logic [COUNT-1:0]        WE;
  logic [COUNT*ADDR_W-1:0] ADDR;
  logic [COUNT*DATA_W-1:0] WDATA;
  logic [COUNT-1:0]        ACK;
  logic [DATA_W-1:0]       RDATA;
  logic                    RAM_REQ;
  logic                    RAM_WE;
  logic [ADDR_W-1:0]       RAM_ADDR;
  logic [DATA_W-1:0]       RAM_WDATA;
  logic                    RAM_ACK;
  logic                    RAM_RVALID;
  logic [DATA_W-1:0]       RAM_RDATA;

  int errors = 0;
  int checks = 0;

  ram_arbiter #(.COUNT(COUNT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .REQ        (REQ),
    .WE         (WE),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .ACK        (ACK),
    .RDATA      (RDATA),
    .RAM_REQ    (RAM_REQ),
    .RAM_WE     (RAM_WE),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_ACK    (RAM_ACK),
    .RAM_RVALID (RAM_RVALID),
    .RAM_RDATA  (RAM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    RAM_ACK = 1'b0; RAM_RVALID = 1'b0; RAM_RDATA = '0;
    tick();
    tick();
    RESET_n = 1'b1;
    tick();
  endtask

  int order[$];
  int exp_order[6] = '{0, 1, 2, 3, 4, 0};
  logic quiet;

  initial begin
    do_reset();
    check("reset_ack", 32'(ACK), 32'h0);
    check("reset_ram_req", 32'(RAM_REQ), 32'h0);
    check("reset_rdata", 32'(RDATA), 32'h0);
    check("reset_ram_addr", 32'(RAM_ADDR), 32'h0);

    // Single read, RAM_ACK after 2 cycles, data 3 cycles later
    REQ[0] = 1'b1; WE[0] = 1'b0; ADDR[0 +: ADDR_W] = 21'h00100;
    tick();
    check("rd_ram_req", 32'(RAM_REQ), 32'h1);
    check("rd_ram_addr", 32'(RAM_ADDR), 32'h100);
    check("rd_ram_we", 32'(RAM_WE), 32'h0);
    tick();
    check("rd_ram_req_hold", 32'(RAM_REQ), 32'h1);
    RAM_ACK = 1'b1;
    tick();
    RAM_ACK = 1'b0;
    check("rd_ram_req_drop", 32'(RAM_REQ), 32'h0);
    check("rd_no_early_ack", 32'(ACK), 32'h0);
    tick();
    tick();
    RAM_RVALID = 1'b1; RAM_RDATA = 16'hA5A5;
    tick();
    check("rd_ack", 32'(ACK), 32'h1);
    check("rd_rdata", 32'(RDATA), 32'hA5A5);
    RAM_RVALID = 1'b0; REQ = '0;
    tick();
    check("rd_ack_one_pulse", 32'(ACK), 32'h0);
    check("rd_rdata_hold", 32'(RDATA), 32'hA5A5);

    // Round-robin order with all requesters writing and RAM_ACK immediate
    do_reset();
    for (int i = 0; i < COUNT; i++) begin
      ADDR[i*ADDR_W +: ADDR_W]  = ADDR_W'(i * 16);
      WDATA[i*DATA_W +: DATA_W] = DATA_W'(32'h1000 + i);
    end
    WE = '1; REQ = '1; RAM_ACK = 1'b1;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      tick();
      if (ACK != '0) begin
        check("rr_ack_onehot", 32'($onehot(ACK)), 32'h1);
        for (int i = 0; i < COUNT; i++) begin
          if (ACK[i]) begin
            order.push_back(i);
            check("rr_wdata", 32'(RAM_WDATA), 32'(32'h1000 + i));
          end
        end
        if (order.size() >= 6) REQ = '0;
      end
    end
    RAM_ACK = 1'b0;
    check("rr_ack_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) check("rr_order", 32'(order[i]), 32'(exp_order[i]));
    end
    tick();
    check("rr_idle_ack", 32'(ACK), 32'h0);
    check("rr_idle_ram_req", 32'(RAM_REQ), 32'h0);

    // Read with RAM_ACK and RAM_RVALID in the same cycle
    REQ[1] = 1'b1; WE[1] = 1'b0; ADDR[ADDR_W +: ADDR_W] = 21'h1ABCD;
    RAM_ACK = 1'b1; RAM_RVALID = 1'b1; RAM_RDATA = 16'h1234;
    tick();
    check("same_ram_req", 32'(RAM_REQ), 32'h1);
    check("same_ram_addr", 32'(RAM_ADDR), 32'h1ABCD);
    tick();
    check("same_ack", 32'(ACK), 32'h2);
    check("same_rdata", 32'(RDATA), 32'h1234);
    check("same_ram_req_drop", 32'(RAM_REQ), 32'h0);
    REQ = '0; RAM_ACK = 1'b0; RAM_RVALID = 1'b0;
    tick();
    check("same_ack_single", 32'(ACK), 32'h0);

    // Requester 2 withdraws while requester 1 is in ISSUE
    REQ[1] = 1'b1; WE[1] = 1'b1; WDATA[DATA_W +: DATA_W] = 16'hC0DE;
    tick();
    check("wd_ram_wdata", 32'(RAM_WDATA), 32'hC0DE);
    REQ[2] = 1'b1;
    tick();
    REQ[2] = 1'b0;
    tick();
    RAM_ACK = 1'b1;
    tick();
    check("wd_ack1", 32'(ACK), 32'h2);
    RAM_ACK = 1'b0; REQ = '0;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (RAM_REQ || ACK != '0) quiet = 1'b0;
    end
    check("wd_no_req2_service", 32'(quiet), 32'h1);

    // Reset during READ_WAIT, late RAM_RVALID must be ignored
    REQ[0] = 1'b1; WE[0] = 1'b0;
    tick();
    RAM_ACK = 1'b1;
    tick();
    RAM_ACK = 1'b0;
    RESET_n = 1'b0; REQ = '0;
    #1;
    check("rst_mid_ram_req", 32'(RAM_REQ), 32'h0);
    check("rst_mid_rdata", 32'(RDATA), 32'h0);
    tick();
    RESET_n = 1'b1;
    RAM_RVALID = 1'b1; RAM_RDATA = 16'hBEEF;
    tick();
    RAM_RVALID = 1'b0;
    check("rst_late_rvalid_ack", 32'(ACK), 32'h0);
    check("rst_late_rvalid_rdata", 32'(RDATA), 32'h0);
    tick();
    check("rst_late_rvalid_ack2", 32'(ACK), 32'h0);
    REQ[0] = 1'b1; WE[0] = 1'b1; WDATA[0 +: DATA_W] = 16'h5555; RAM_ACK = 1'b1;
    tick();
    check("rst_next_ram_req", 32'(RAM_REQ), 32'h1);
    check("rst_next_ram_wdata", 32'(RAM_WDATA), 32'h5555);
    tick();
    check("rst_next_ack", 32'(ACK), 32'h1);
    REQ = '0; RAM_ACK = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
